// File: rtl/am2950.sv
// Am2950-style bidirectional port: one word per direction (AB, BA) with full flags.
// Optional sticky overrun flag, built only when AM2950_OVR_EN is defined.
module am2950 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_,
    input  logic [WIDTH-1:0] a_in,
    input  logic             a_wr,
    input  logic             a_rd,
    output logic [WIDTH-1:0] a_out,
    output logic             a_full,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_wr,
    input  logic             b_rd,
    output logic [WIDTH-1:0] b_out,
    input  logic             b_oe_,
    output logic             b_be,
    output logic             ab_full,
    output logic             ovr
);

    // Path 0 is A-to-B (written by A, read by B); path 1 is B-to-A.
    logic [WIDTH-1:0] din    [2];
    logic [WIDTH-1:0] data_q [2];
    logic             full_q [2];
    logic [1:0]       wr;
    logic [1:0]       rd;

    assign din[0] = a_in;
    assign din[1] = b_in;
    assign wr     = {b_wr, a_wr};
    assign rd     = {a_rd, b_rd};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_path
            logic [WIDTH-1:0] data_reg;
            logic             full_reg;
            logic             accept;

            // A write lands when empty, or when the held word is consumed in the same cycle.
            assign accept = wr[gi] & (~full_reg | rd[gi]);

            always_ff @(posedge clk or negedge clr_) begin
                if (!clr_) begin
                    data_reg <= '0;
                    full_reg <= 1'b0;
                end else if (accept) begin
                    data_reg <= din[gi];
                    full_reg <= 1'b1;
                end else if (rd[gi]) begin
                    full_reg <= 1'b0;
                end
            end

            assign data_q[gi] = data_reg;
            assign full_q[gi] = full_reg;
        end
    endgenerate

    assign b_out   = data_q[0];
    assign ab_full = full_q[0];
    assign a_out   = data_q[1];
    assign a_full  = full_q[1];
    assign b_be    = ~b_oe_ & full_q[0];

`ifdef AM2950_OVR_EN
    logic ovr_reg;
    logic ovr_next;
    logic rej_ab;
    logic rej_ba;
    logic ovr_clr;

    assign rej_ab  = a_wr & full_q[0] & ~b_rd;
    assign rej_ba  = b_wr & full_q[1] & ~a_rd;
    // Double read-acknowledge on two empty registers is the software clear.
    assign ovr_clr = a_rd & b_rd & ~full_q[0] & ~full_q[1];

    always_comb begin
        ovr_next = ovr_reg;
        if (rej_ab | rej_ba) begin
            ovr_next = 1'b1;
        end else if (ovr_clr) begin
            ovr_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            ovr_reg <= 1'b0;
        end else begin
            ovr_reg <= ovr_next;
        end
    end

    assign ovr = ovr_reg;
`else
    assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_am2950.sv
// Scoreboard bench for am2950: stimulus queues expected outputs, a negedge monitor compares.
module tb_am2950;

`ifdef AM2950_OVR_EN
    localparam logic OVR = 1'b1;
`else
    localparam logic OVR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr_ = 1'b0;
    logic [7:0] a_in = '0, b_in = '0;
    logic       a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0, b_oe_ = 1;
    logic [7:0] a_out, b_out;
    logic       a_full, ab_full, b_be, ovr;

    logic [3:0] a4_in = '0, b4_in = '0;
    logic       a4_wr = 0, a4_rd = 0, b4_wr = 0, b4_rd = 0, b4_oe_ = 1;
    logic [3:0] a4_out, b4_out;
    logic       a4_full, ab4_full, b4_be, ovr4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      nm;
        logic [7:0] a_out;
        logic [7:0] b_out;
        logic       abf;
        logic       af;
        logic       bbe;
        logic       ovr;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    am2950 #(.WIDTH(8)) dut (
        .clk(clk), .clr_(clr_),
        .a_in(a_in), .a_wr(a_wr), .a_rd(a_rd), .a_out(a_out), .a_full(a_full),
        .b_in(b_in), .b_wr(b_wr), .b_rd(b_rd), .b_out(b_out),
        .b_oe_(b_oe_), .b_be(b_be), .ab_full(ab_full), .ovr(ovr)
    );

    am2950 #(.WIDTH(4)) dut4 (
        .clk(clk), .clr_(clr_),
        .a_in(a4_in), .a_wr(a4_wr), .a_rd(a4_rd), .a_out(a4_out), .a_full(a4_full),
        .b_in(b4_in), .b_wr(b4_wr), .b_rd(b4_rd), .b_out(b4_out),
        .b_oe_(b4_oe_), .b_be(b4_be), .ab_full(ab4_full), .ovr(ovr4)
    );

    task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: DUT outputs are stable mid-cycle, so compare on every falling edge with a pending entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                $display("txn %-10s a_out=%h b_out=%h ab_full=%b a_full=%b b_be=%b ovr=%b",
                         e.nm, a_out, b_out, ab_full, a_full, b_be, ovr);
                chk(e.nm, "a_out",   a_out,          e.a_out);
                chk(e.nm, "b_out",   b_out,          e.b_out);
                chk(e.nm, "ab_full", {7'd0, ab_full}, {7'd0, e.abf});
                chk(e.nm, "a_full",  {7'd0, a_full},  {7'd0, e.af});
                chk(e.nm, "b_be",    {7'd0, b_be},    {7'd0, e.bbe});
                chk(e.nm, "ovr",     {7'd0, ovr},     {7'd0, e.ovr});
            end
        end
    end

    function automatic exp_t mk(input string nm, input logic [7:0] ea, input logic [7:0] eb,
                                input logic abf, input logic af, input logic bbe, input logic eo);
        exp_t e;
        e.nm = nm; e.a_out = ea; e.b_out = eb;
        e.abf = abf; e.af = af; e.bbe = bbe; e.ovr = eo;
        return e;
    endfunction

    // One clock: strobes are applied for a single edge; b_oe_ is held through the sample point.
    task automatic cyc(input string nm,
                       input logic aw, input logic [7:0] ai, input logic br,
                       input logic bw, input logic [7:0] bi, input logic ar, input logic boe,
                       input logic [7:0] ea, input logic [7:0] eb,
                       input logic abf, input logic af, input logic bbe, input logic eo);
        a_wr = aw; a_in = ai; b_rd = br; b_wr = bw; b_in = bi; a_rd = ar; b_oe_ = boe;
        @(posedge clk);
        #1;
        a_wr = 0; b_rd = 0; b_wr = 0; a_rd = 0;
        q.push_back(mk(nm, ea, eb, abf, af, bbe, eo));
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        clr_ = 1'b1;
        //   name          aw  a_in   br bw b_in  ar oe   a_out  b_out  abf af bbe ovr
        cyc("idle",        0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0);
        cyc("wr_a5",       1, 8'hA5, 0, 0, 8'h00, 0, 1, 8'h00, 8'hA5, 1, 0, 0, 0);
        cyc("oe_on",       0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 8'hA5, 1, 0, 1, 0);

        // Asynchronous reset mid-cycle with a word pending.
        clr_ = 1'b0;
        #1;
        q.push_back(mk("reset", 8'h00, 8'h00, 0, 0, 0, 0));
        @(negedge clk);
        #1;
        clr_ = 1'b1;

        cyc("wr_a5_2",     1, 8'hA5, 0, 0, 8'h00, 0, 0, 8'h00, 8'hA5, 1, 0, 1, 0);
        cyc("b_rd",        0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 8'hA5, 0, 0, 0, 0);
        cyc("underrun",    0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 8'hA5, 0, 0, 0, 0);
        cyc("wr_11",       1, 8'h11, 0, 0, 8'h00, 0, 0, 8'h00, 8'h11, 1, 0, 1, 0);
        cyc("overrun",     1, 8'h22, 0, 0, 8'h00, 0, 0, 8'h00, 8'h11, 1, 0, 1, OVR);
        cyc("rd_11",       0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 8'h11, 0, 0, 0, OVR);
        cyc("wr_33",       1, 8'h33, 0, 0, 8'h00, 0, 0, 8'h00, 8'h33, 1, 0, 1, OVR);
        cyc("pass_44",     1, 8'h44, 1, 0, 8'h00, 0, 0, 8'h00, 8'h44, 1, 0, 1, OVR);
        cyc("rd_44",       0, 8'h00, 1, 0, 8'h00, 0, 0, 8'h00, 8'h44, 0, 0, 0, OVR);
        cyc("ovr_clr",     0, 8'h00, 1, 0, 8'h00, 1, 0, 8'h00, 8'h44, 0, 0, 0, 0);
        cyc("bidir",       1, 8'h5A, 0, 1, 8'hC3, 0, 1, 8'hC3, 8'h5A, 1, 1, 0, 0);
        cyc("a_rd",        0, 8'h00, 0, 0, 8'h00, 1, 1, 8'hC3, 8'h5A, 1, 0, 0, 0);
        cyc("wr_ba_77",    0, 8'h00, 0, 1, 8'h77, 0, 1, 8'h77, 8'h5A, 1, 1, 0, 0);
        cyc("ba_overrun",  0, 8'h00, 0, 1, 8'h88, 0, 1, 8'h77, 8'h5A, 1, 1, 0, OVR);
        cyc("both_rd",     0, 8'h00, 1, 0, 8'h00, 1, 1, 8'h77, 8'h5A, 0, 0, 0, OVR);
        cyc("ovr_clr2",    0, 8'h00, 1, 0, 8'h00, 1, 1, 8'h77, 8'h5A, 0, 0, 0, 0);

        // WIDTH=4 instance: A-to-B transfer of 4'h9.
        a4_wr = 1; a4_in = 4'h9; b4_oe_ = 0;
        @(posedge clk);
        #1;
        a4_wr = 0;
        $display("txn w4_wr_9   b_out=%h ab_full=%b b_be=%b", b4_out, ab4_full, b4_be);
        chk("w4_wr_9", "b_out",   {4'd0, b4_out},   8'h09);
        chk("w4_wr_9", "ab_full", {7'd0, ab4_full}, 8'h01);
        chk("w4_wr_9", "b_be",    {7'd0, b4_be},    8'h01);
        b4_rd = 1;
        @(posedge clk);
        #1;
        b4_rd = 0;
        $display("txn w4_rd     b_out=%h ab_full=%b b_be=%b", b4_out, ab4_full, b4_be);
        chk("w4_rd", "ab_full", {7'd0, ab4_full}, 8'h00);
        chk("w4_rd", "b_be",    {7'd0, b4_be},    8'h00);

        // Give the monitor a bounded window to drain the scoreboard.
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/am2950.md
Name: am2950

Overview:
- Parameterised bidirectional I/O port with handshake flags, modelled on the Am2950 and synchronised to one clock.
- Holds one data word per direction: A-to-B (AB) and B-to-A (BA).
- Sits directly upstream of the inverting bus driver/receiver. `b_out` feeds the driver's `d` input, `b_be` feeds its `be` input, and the driver's receive output `r` returns on `b_in`.
- Full/empty flags give the handshake so producer and consumer on each side never overwrite or double-read a word.

Parameters:
- WIDTH, 8, data width of both registers and all data ports.

Ports:
- clk, input, 1, rising-edge clock.
- clr_, input, 1, asynchronous active-low reset.
- a_in, input, WIDTH, A-side write data.
- a_wr, input, 1, A-side write strobe, sampled at clk.
- a_rd, input, 1, A-side read acknowledge; consumes the BA word.
- a_out, output, WIDTH, BA register contents.
- a_full, output, 1, BA register holds an unread word.
- b_in, input, WIDTH, B-side write data (from the driver's receive output).
- b_wr, input, 1, B-side write strobe.
- b_rd, input, 1, B-side read acknowledge; consumes the AB word.
- b_out, output, WIDTH, AB register contents; feeds the bus driver's `d`.
- b_oe_, input, 1, active-low B-bus output enable request.
- b_be, output, 1, bus-driver enable = ~b_oe_ & ab_full (combinational).
- ab_full, output, 1, AB register holds an unread word.
- ovr, output, 1, sticky overrun flag; see Optional Feature.

Behaviour:
- Reset (clr_ low, asynchronous): AB and BA registers = 0; ab_full = 0; a_full = 0; ovr = 0. b_be = 0 follows, since ab_full = 0.
- All state changes happen on the rising edge of clk; strobes are single-cycle level-sampled.
- AB path, per edge, with F = ab_full:
  - a_wr=0, b_rd=0: hold.
  - a_wr=1, F=0: AB <= a_in, F <= 1. A simultaneous b_rd is an underrun and is ignored.
  - a_wr=0, b_rd=1, F=1: F <= 0; data unchanged.
  - a_wr=0, b_rd=1, F=0: no effect (underrun ignored).
  - a_wr=1, b_rd=1, F=1: pass-through. Old word is consumed this cycle, AB <= a_in, F stays 1.
  - a_wr=1, b_rd=0, F=1: write rejected; AB and F unchanged (overrun).
- BA path: identical rules with b_wr/b_in writing, a_rd reading, a_full as the flag.
- Paths are independent; any combination of all four strobes in one cycle is legal.
- Write-to-flag latency is 1 clk; the data is visible on the out port in the same cycle the flag rises.
- a_out/b_out always show register contents. Tri-state is the downstream driver's job; this block never drives Z.
- Reset asserted mid-transfer wins immediately; pending words are lost.
- Deasserting clr_ takes effect at the next clk edge.

Optional Feature:
- Macro: AM2950_OVR_EN.
- Defined:
  - ovr is set on any rejected write (AB or BA overrun case).
  - ovr stays set until a cycle where a_rd and b_rd are both 1 with neither flag set, or until reset.
  - A rejected write and that clearing condition cannot coincide: the clear requires both flags 0, and a rejected write requires a flag 1.
- Undefined: no overrun logic is generated; ovr is tied to 0.

Test Plan:
- Reset: clr_=0 mid-cycle with ab_full=1 → ab_full, a_full, ovr, b_be = 0 immediately; b_out=0.
- A→B transfer: a_in=8'hA5, a_wr=1 for one cycle → next edge b_out=A5 and ab_full=1. b_oe_=0 → b_be=1. b_rd=1 for one cycle → ab_full=0, b_be=0.
- Overrun:
  - Sequence: write 8'h11, then a_wr=1 with a_in=8'h22 and no b_rd → b_out stays 11, ab_full=1.
  - With AM2950_OVR_EN: ovr=1. Without it: ovr=0.
- Pass-through: ab_full=1 holding 8'h33; same cycle a_wr=1 with a_in=8'h44 and b_rd=1 → b_out=44, ab_full stays 1, ovr unchanged.
- Bidirectional concurrency: a_wr=1 (8'h5A) and b_wr=1 (8'hC3) in the same cycle → b_out=5A, a_out=C3, both flags 1. Next cycle a_rd=1 → a_full=0, ab_full still 1.
- Underrun: empty AB, b_rd=1 → ab_full stays 0, b_out unchanged, ovr unchanged. WIDTH=4 build repeats the A→B transfer test with 4'h9.
